// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and access sequencer that lets two requesters share the
// single-port data memory. Each access runs IDLE -> ACCESS -> [READ_WAIT] -> RESP.
module data_mem_arbiter #(
  parameter  int DATA_WIDTH  = 8,
  parameter  int MEMORY_SIZE = 64,
  localparam int ADDR_WIDTH  = $clog2(MEMORY_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    READ_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t                state_q,  state_d;
  logic                  gnt_q,    gnt_d;
  logic                  last_q,   last_d;
  logic                  we_q,     we_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Under contention the requester not served last wins.
          gnt_d   = (req0 && req1) ? ~last_q : req1;
          last_d  = gnt_d;
          we_d    = gnt_d ? we1    : we0;
          addr_d  = gnt_d ? addr1  : addr0;
          wdata_d = gnt_d ? wdata1 : wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS:    state_d = we_q ? RESP : READ_WAIT;
      READ_WAIT: begin
        if (gnt_q) rdata1_d = mem_rdata;
        else       rdata0_d = mem_rdata;
        state_d = RESP;
      end
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // The latched request doubles as the memory port, so it holds between accesses
  // and mem_we is purely state-decoded, dropping the instant reset clears state.
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = (state_q == ACCESS) && we_q;
    ack0      = (state_q == RESP) && !gnt_q;
    ack1      = (state_q == RESP) &&  gnt_q;
    busy      = (state_q != IDLE);
    rdata0    = rdata0_q;
    rdata1    = rdata1_q;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a registered-read memory model.
module tb_data_mem_arbiter;

  logic       clk;
  logic       reset;
  logic       req0, req1, we0, we1;
  logic [5:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [64];
  logic       loaded = 1'b0;
  int         ack0_cnt = 0;
  int         ack1_cnt = 0;
  int         we_cnt = 0;

  data_mem_arbiter #(.DATA_WIDTH(8), .MEMORY_SIZE(64)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 7 + 3);
  endfunction

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      loaded <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (ack0)   ack0_cnt++;
    if (ack1)   ack1_cnt++;
    if (mem_we) we_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int c0, c1, k, base0, base_we, seq_n, last_cyc;
  int order [4];
  logic p0, p1;

  initial begin
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    tick();
    tick();
    check_eq("rst_ack0", {31'd0, ack0}, 0);
    check_eq("rst_ack1", {31'd0, ack1}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_mem_we", {31'd0, mem_we}, 0);
    check_eq("rst_mem_addr", {26'd0, mem_addr}, 0);
    check_eq("rst_mem_wdata", {24'd0, mem_wdata}, 0);
    check_eq("rst_rdata0", {24'd0, rdata0}, 0);
    check_eq("rst_rdata1", {24'd0, rdata1}, 0);
    reset = 1'b0;

    // Write from requester 0
    base_we = we_cnt;
    req0 = 1; we0 = 1; addr0 = 6'd5; wdata0 = 8'hA5;
    tick();
    check_eq("wr_mem_we", {31'd0, mem_we}, 1);
    check_eq("wr_mem_addr", {26'd0, mem_addr}, 5);
    check_eq("wr_mem_wdata", {24'd0, mem_wdata}, 32'hA5);
    check_eq("wr_busy", {31'd0, busy}, 1);
    check_eq("wr_ack0_early", {31'd0, ack0}, 0);
    tick();
    check_eq("wr_ack0", {31'd0, ack0}, 1);
    check_eq("wr_ack1", {31'd0, ack1}, 0);
    check_eq("wr_we_resp", {31'd0, mem_we}, 0);
    req0 = 0; we0 = 0;
    tick();
    check_eq("wr_idle_busy", {31'd0, busy}, 0);
    check_eq("wr_ack0_drop", {31'd0, ack0}, 0);
    check_eq("wr_mem_data", {24'd0, mem[5]}, 32'hA5);
    check_eq("wr_we_cycles", we_cnt - base_we, 1);

    // Read from requester 1 of the location just written
    req1 = 1; we1 = 0; addr1 = 6'd5;
    c1 = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ack1) begin c1 = i; break; end
    end
    check_eq("rd_latency", c1, 3);
    check_eq("rd_rdata1", {24'd0, rdata1}, 32'hA5);
    check_eq("rd_rdata0_kept", {24'd0, rdata0}, 0);
    req1 = 0;
    tick();
    check_eq("rd_rdata1_held", {24'd0, rdata1}, 32'hA5);

    // Continuous contention right after reset
    do_reset();
    req0 = 1; we0 = 0; addr0 = 6'd10;
    req1 = 1; we1 = 0; addr1 = 6'd20;
    seq_n = 0; last_cyc = 0; p0 = 0; p1 = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (p0) check_eq("cont_ack0_pulse", {31'd0, ack0}, 0);
      if (p1) check_eq("cont_ack1_pulse", {31'd0, ack1}, 0);
      if (ack0 && ack1) check_eq("cont_both_ack", 1, 0);
      p0 = ack0; p1 = ack1;
      if (ack0 || ack1) begin
        order[seq_n] = ack1 ? 1 : 0;
        seq_n++;
        last_cyc = i;
        if (seq_n == 4) begin
          req0 = 0; req1 = 0;
          break;
        end
      end
    end
    check_eq("cont_acks", seq_n, 4);
    if (seq_n == 4) begin
      check_eq("cont_order0", order[0], 0);
      check_eq("cont_order1", order[1], 1);
      check_eq("cont_order2", order[2], 0);
      check_eq("cont_order3", order[3], 1);
    end
    check_eq("cont_last_cycle", last_cyc, 15);
    check_eq("cont_rdata0", {24'd0, rdata0}, {24'd0, init_val(10)});
    check_eq("cont_rdata1", {24'd0, rdata1}, {24'd0, init_val(20)});
    tick();

    // Requester 1 arrives while requester 0's read is in ACCESS
    req0 = 1; we0 = 0; addr0 = 6'd30;
    tick();
    check_eq("late_busy", {31'd0, busy}, 1);
    req1 = 1; we1 = 1; addr1 = 6'd31; wdata1 = 8'h5A;
    c0 = 0; c1 = 0;
    for (int i = 2; i <= 14; i++) begin
      tick();
      if (ack0 && c0 == 0) begin
        c0 = i; req0 = 0;
        check_eq("late_ack1_blocked", {31'd0, ack1}, 0);
      end
      if (ack1 && c1 == 0) begin c1 = i; req1 = 0; break; end
    end
    check_eq("late_ack0_cycle", c0, 3);
    check_eq("late_ack1_cycle", c1, 6);
    check_eq("late_rdata0", {24'd0, rdata0}, {24'd0, init_val(30)});
    tick();
    check_eq("late_mem31", {24'd0, mem[31]}, 32'h5A);

    // Asynchronous reset in the middle of a write's ACCESS cycle
    base0 = ack0_cnt;
    req0 = 1; we0 = 1; addr0 = 6'd40; wdata0 = 8'hEE;
    tick();
    check_eq("arst_we_before", {31'd0, mem_we}, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_mem_we", {31'd0, mem_we}, 0);
    check_eq("arst_busy", {31'd0, busy}, 0);
    check_eq("arst_ack0", {31'd0, ack0}, 0);
    check_eq("arst_mem_addr", {26'd0, mem_addr}, 0);
    check_eq("arst_mem_wdata", {24'd0, mem_wdata}, 0);
    check_eq("arst_rdata0", {24'd0, rdata0}, 0);
    check_eq("arst_rdata1", {24'd0, rdata1}, 0);
    req0 = 0; we0 = 0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_eq("arst_mem40", {24'd0, mem[40]}, {24'd0, init_val(40)});
    check_eq("arst_no_ack", ack0_cnt - base0, 0);

    // Request held through its ack is served again
    base0 = ack0_cnt;
    req0 = 1; we0 = 0; addr0 = 6'd12;
    k = 0; last_cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ack0) begin
        k++;
        if (k == 2) begin last_cyc = i; req0 = 0; break; end
      end
    end
    tick();
    tick();
    tick();
    check_eq("hold_ack_count", ack0_cnt - base0, 2);
    check_eq("hold_second_ack", last_cyc, 7);
    check_eq("hold_rdata0", {24'd0, rdata0}, {24'd0, init_val(12)});
    check_eq("hold_idle", {31'd0, busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
